// File: rtl/pll_dig_loop.sv
// pll_dig_loop: digital PI loop filter for a frequency-locked loop.
//
// The divided feedback clock fdiv is synchronised into the fref domain and
// its period is measured in fref cycles. Each finished measurement is
// compared against the target period div_n. The signed error feeds an
// integrator and a proportional term, and the result drives the DAC word.
// A run of in-tolerance updates asserts locked.
//
// Ports
//   fref   in   1         sole clock, rising edge
//   rst    in   1         synchronous, active-low reset
//   fdiv   in   1         divided feedback clock, asynchronous to fref
//   en     in   1         loop enable
//   div_n  in   CNT_W     target fdiv period in fref cycles (values < 2 act as 2)
//   dac    out  DAC_W     registered DAC control word
//   err    out  CNT_W+1   signed error of the last update (measured - target)
//   upd    out  1         one-cycle pulse when dac/err/locked were updated
//   locked out  1         lock indicator
module pll_dig_loop #(
   parameter int              DAC_W    = 20,
   parameter int              CNT_W    = 12,
   parameter int              KP_SHIFT = 4,
   parameter int              KI_SHIFT = 0,
   parameter logic [DAC_W-1:0] DAC_INIT = {1'b1, {(DAC_W-1){1'b0}}},
   parameter int              LOCK_TOL = 0,
   parameter int              LOCK_CNT = 8
) (
   input  logic                    fref,
   input  logic                    rst,
   input  logic                    fdiv,
   input  logic                    en,
   input  logic [CNT_W-1:0]        div_n,
   output logic [DAC_W-1:0]        dac,
   output logic signed [CNT_W:0]   err,
   output logic                    upd,
   output logic                    locked
);

   localparam int SH_MAX = (KP_SHIFT > KI_SHIFT) ? KP_SHIFT : KI_SHIFT;
   // Wide enough that integ plus a fully shifted error can never wrap.
   localparam int MW     = DAC_W + CNT_W + SH_MAX + 2;
   localparam int LR_W   = $clog2(LOCK_CNT + 1);

   localparam logic [CNT_W-1:0]      CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]      TGT_MIN = {{(CNT_W-2){1'b0}}, 2'b10};
   localparam logic [LR_W-1:0]       LR_MAX  = LOCK_CNT[LR_W-1:0];
   localparam logic [LR_W-1:0]       LR_ONE  = {{(LR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W:0]        TOL     = LOCK_TOL[CNT_W:0];
   localparam logic signed [MW-1:0]  DAC_TOP = {{(MW-DAC_W){1'b0}}, {DAC_W{1'b1}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEAS = 2'd1,
      UPD  = 2'd2
   } state_t;

   state_t                   state, state_nx;
   logic                     s1, s2, s3;
   logic                     rise, evt;
   logic [CNT_W-1:0]         cnt, meas, tgt;
   logic [DAC_W-1:0]         integ, integ_nx, dac_nx;
   logic [LR_W-1:0]          lock_run, lr_nx;
   logic signed [CNT_W:0]    e;
   logic [CNT_W:0]           e_abs;
   logic                     in_tol;
   logic signed [MW-1:0]     e_ext, sum_i, sum_p;

   function automatic logic [DAC_W-1:0] clamp_dac(input logic signed [MW-1:0] v);
      if (v[MW-1])
         return '0;
      else if (v > DAC_TOP)
         return '1;
      else
         return v[DAC_W-1:0];
   endfunction

   // s1 is the metastability flop; a rise is seen one flop further down.
   always_ff @(posedge fref) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= fdiv;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   // A measurement ends on a rise or when the counter has run out (timeout).
   assign evt  = (state != IDLE) && (rise || (cnt == CNT_MAX));

   always_ff @(posedge fref) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (rise) state_nx = MEAS;
         MEAS:    if (evt)  state_nx = UPD;
         UPD:     state_nx = evt ? UPD : MEAS;
         default: state_nx = IDLE;
      endcase
      if (!en)
         state_nx = IDLE;
   end

   // Loop filter arithmetic on the captured measurement.
   always_comb begin
      e        = $signed({1'b0, meas}) - $signed({1'b0, tgt});
      e_ext    = {{(MW-CNT_W-1){e[CNT_W]}}, e};
      sum_i    = $signed({{(MW-DAC_W){1'b0}}, integ}) + (e_ext <<< KI_SHIFT);
      integ_nx = clamp_dac(sum_i);
      sum_p    = $signed({{(MW-DAC_W){1'b0}}, integ_nx}) + (e_ext <<< KP_SHIFT);
      dac_nx   = clamp_dac(sum_p);
      e_abs    = e[CNT_W] ? $unsigned(-e) : $unsigned(e);
      in_tol   = (e_abs <= TOL);
      if (!in_tol)
         lr_nx = '0;
      else if (lock_run == LR_MAX)
         lr_nx = LR_MAX;
      else
         lr_nx = lock_run + LR_ONE;
   end

   always_ff @(posedge fref) begin
      if (!rst) begin
         cnt      <= '0;
         meas     <= '0;
         tgt      <= '0;
         integ    <= DAC_INIT;
         dac      <= DAC_INIT;
         err      <= '0;
         upd      <= 1'b0;
         locked   <= 1'b0;
         lock_run <= '0;
      end else begin
         upd <= 1'b0;
         if (!en) begin
            // dac, integ and err deliberately hold while disabled.
            cnt      <= '0;
            lock_run <= '0;
            locked   <= 1'b0;
         end else begin
            if (rise || evt)
               cnt <= CNT_ONE;
            else if ((state != IDLE) && (cnt != CNT_MAX))
               cnt <= cnt + CNT_ONE;

            if (evt) begin
               meas <= cnt;
               tgt  <= (div_n < TGT_MIN) ? TGT_MIN : div_n;
            end

            if (state == UPD) begin
               integ    <= integ_nx;
               dac      <= dac_nx;
               err      <= e;
               upd      <= 1'b1;
               lock_run <= lr_nx;
               locked   <= (lr_nx == LR_MAX);
            end
         end
      end
   end

endmodule

// File: tb/tb_pll_dig_loop.sv
// tb_pll_dig_loop: self-checking bench for pll_dig_loop.
// The reference model works on edge indices: a rise sampled by the DUT is
// acted on two edges later, a measurement is the edge distance between
// consecutive events, and its update appears on the following edge.
module tb_pll_dig_loop;

   localparam int     DAC_W    = 20;
   localparam int     CNT_W    = 12;
   localparam int     KP_SHIFT = 4;
   localparam int     KI_SHIFT = 0;
   localparam int     LOCK_TOL = 0;
   localparam int     LOCK_CNT = 8;
   localparam longint DAC_MAX  = (longint'(1) << DAC_W) - 1;
   localparam longint DAC_RST  = longint'(1) << (DAC_W - 1);
   localparam int     CNT_TOP  = (1 << CNT_W) - 1;

   logic                  fref = 1'b0;
   logic                  rst;
   logic                  fdiv;
   logic                  en;
   logic [CNT_W-1:0]      div_n;
   logic [DAC_W-1:0]      dac;
   logic signed [CNT_W:0] err;
   logic                  upd;
   logic                  locked;

   // ---------------- clock / reset ----------------
   always #5 fref = ~fref;

   pll_dig_loop #(
      .DAC_W(DAC_W), .CNT_W(CNT_W), .KP_SHIFT(KP_SHIFT), .KI_SHIFT(KI_SHIFT),
      .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)
   ) dut (
      .fref(fref), .rst(rst), .fdiv(fdiv), .en(en), .div_n(div_n),
      .dac(dac), .err(err), .upd(upd), .locked(locked)
   );

   // ---------------- scoreboard ----------------
   int               n_checks = 0;
   int               n_pass   = 0;
   logic [DAC_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct { int meas; int tgt; } cap_t;
   cap_t   cap_q[$];
   int     n_edge = 0;
   bit     hist[3];
   bit     armed;
   int     t_last;
   longint m_integ, m_dac;
   int     m_err, m_run;
   bit     m_locked, m_upd;

   function automatic longint clampd(input longint v);
      if (v < 0) return 0;
      if (v > DAC_MAX) return DAC_MAX;
      return v;
   endfunction

   task automatic model_edge();
      int e;
      int ae;
      bit r;
      cap_t c;
      m_upd = 1'b0;
      if (!rst) begin
         hist = '{0, 0, 0};
         cap_q.delete();
         armed = 0; m_integ = DAC_RST; m_dac = DAC_RST;
         m_err = 0; m_run = 0; m_locked = 0;
      end else begin
         if (!en) begin
            armed = 0; cap_q.delete(); m_run = 0; m_locked = 0;
         end else begin
            if (cap_q.size() > 0) begin
               c = cap_q.pop_front();
               e = c.meas - c.tgt;
               m_integ = clampd(m_integ + longint'(e) * (longint'(1) << KI_SHIFT));
               m_dac   = clampd(m_integ + longint'(e) * (longint'(1) << KP_SHIFT));
               m_err   = e;
               ae = (e < 0) ? -e : e;
               if (ae <= LOCK_TOL) begin
                  if (m_run < LOCK_CNT) m_run++;
               end else begin
                  m_run = 0;
               end
               m_locked = (m_run == LOCK_CNT);
               m_upd = 1'b1;
            end
            r = hist[1] && !hist[2];
            if (!armed) begin
               if (r) begin armed = 1; t_last = n_edge; end
            end else if (r || (n_edge - t_last >= CNT_TOP)) begin
               c.meas = n_edge - t_last;
               c.tgt  = (int'(div_n) < 2) ? 2 : int'(div_n);
               cap_q.push_back(c);
               t_last = n_edge;
            end
         end
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = fdiv;
      end
      n_edge++;
   endtask

   // ---------------- drivers ----------------
   int ph = 0, per = 2, pmin = 2, pmax = 2;
   bit hold_low = 0;

   task automatic set_period(input int lo, input int hi);
      pmin = lo; pmax = hi; hold_low = 0; ph = 0;
   endtask

   task automatic next_fdiv();
      if (hold_low) begin
         fdiv = 1'b0;
      end else begin
         if (ph == 0) per = $urandom_range(pmax, pmin);
         fdiv = (ph < per / 2);
         ph = (ph + 1 == per) ? 0 : ph + 1;
      end
   endtask

   task automatic step();
      @(negedge fref);
      next_fdiv();
      @(posedge fref);
      model_edge();
      #1;
      check("upd", upd, m_upd);
      check("dac", dac, m_dac);
      check("err", err, m_err);
      check("locked", locked, m_locked);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int nupd;
      int first_lock;
      bit found;
      rst = 1'b0; en = 1'b1; div_n = 12'd4; fdiv = 1'b0;
      set_period(2, 2);

      // Reset with fdiv toggling.
      for (int i = 0; i < 3; i++) step();
      check("rst_dac", dac, DAC_RST);

      // Lock at period 4.
      rst = 1'b1; set_period(4, 4);
      nupd = 0; first_lock = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (upd === 1'b1) nupd++;
         if (locked === 1'b1 && first_lock == 0) first_lock = nupd;
      end
      check("lock_at_upd", first_lock, 8);

      // Enable drop while locked, then re-enable.
      en = 1'b0;
      step();
      check("en_off_locked", locked, 0);
      check("en_off_dac", dac, DAC_RST);
      for (int i = 0; i < 20; i++) step();
      en = 1'b1;
      for (int i = 0; i < 30; i++) step();

      // Slow feedback: period 5 against target 4.
      rst = 1'b0;
      step(); step();
      rst = 1'b1; set_period(5, 5);
      exp_q.push_back(20'd524305);
      exp_q.push_back(20'd524306);
      for (int i = 0; i < 40; i++) begin
         step();
         if (upd === 1'b1) begin
            check("slow_err", err, 1);
            if (exp_q.size() > 0) check("slow_dac", dac, exp_q.pop_front());
         end
      end
      check("slow_q_empty", exp_q.size(), 0);

      // Reset landing on the update cycle.
      set_period(3, 6);
      for (int i = 0; i < 20; i++) step();
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         step();
         if (cap_q.size() > 0) found = 1;
      end
      check("rst_upd_found", found, 1);
      rst = 1'b0;
      step();
      check("rst_upd_dac", dac, DAC_RST);
      check("rst_upd_upd", upd, 0);
      rst = 1'b1;

      // Randomised run: periods, targets and enable all vary.
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) begin
            int lo;
            lo = $urandom_range(10, 2);
            set_period(lo, lo + $urandom_range(15, 0));
         end
         if ($urandom_range(40, 0) == 0) div_n = 12'($urandom_range(20, 0));
         if ($urandom_range(150, 0) == 0) en = ~en;
         step();
      end
      en = 1'b1;

      // Lower clamp: very fast feedback against a huge target.
      div_n = 12'd4095; set_period(2, 3);
      for (int i = 0; i < 500; i++) step();
      check("clamp_lo_dac", dac, 0);

      // Recovery with positive error.
      div_n = 12'd2; set_period(30, 30);
      for (int i = 0; i < 100; i++) step();

      // Timeout: fdiv held low.
      div_n = 12'd4; hold_low = 1;
      nupd = 0;
      for (int i = 0; i < 12300; i++) begin
         step();
         if (upd === 1'b1) begin
            nupd++;
            check("tmo_err", err, 4091);
         end
      end
      check("tmo_count", nupd, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
